// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge
//
// Bridge between the 16-bit CPU memory port and two targets: a
// fixed-latency synchronous RAM and a variable-latency memory-mapped I/O
// port with a ready handshake. Addresses at or above IO_BASE go to the
// I/O port and everything below goes to RAM. Read data returns to the CPU
// in order, one word per o_mem_rddatavalid pulse. o_mem_wait holds the CPU
// off whenever a request cannot be taken this cycle.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_mem_*             CPU request (addr, rd, wr, wrdata)
//   o_mem_wait          combinational backpressure to the CPU
//   o_mem_rddata/valid  registered read response to the CPU
//   o_ram_*             RAM command (addr, rd/wr strobes, wrdata)
//   i_ram_rddata        RAM read data, RAM_LATENCY cycles after o_ram_rd
//   o_io_*              I/O request (offset, rd/wr held until ready, wrdata)
//   i_io_rddata/ready   I/O completion and read data
module cpu_mem_bridge #(
  parameter int          RAM_LATENCY     = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] IO_BASE         = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic        o_mem_wait,
  output logic [15:0] o_mem_rddata,
  output logic        o_mem_rddatavalid,
  output logic [15:0] o_ram_addr,
  output logic        o_ram_rd,
  output logic        o_ram_wr,
  output logic [15:0] o_ram_wrdata,
  input  logic [15:0] i_ram_rddata,
  output logic [7:0]  o_io_addr,
  output logic        o_io_rd,
  output logic        o_io_wr,
  output logic [15:0] o_io_wrdata,
  input  logic [15:0] i_io_rddata,
  input  logic        i_io_ready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IO_ACCESS = 2'd1,
    IO_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  state_t state_q, state_d;

  logic        memReq;
  logic        reqIo;
  logic        memWait;
  logic        accept;
  logic        ramAccept;
  logic        ramReadAccept;

  logic [2:0]  count_q, count_d;

  logic        ramRd_q, ramWr_q;
  logic [15:0] ramAddr_q, ramWrdata_q;
  logic [RAM_LATENCY-1:0] valid_q;
  logic [RAM_LATENCY:0]   validShift;
  logic        ramTail;
  logic        ramRespValid_q;

  logic        rdValid_q, rdValid_d;
  logic [15:0] rdData_q, rdData_d;

  logic        ioRd_q, ioRd_d;
  logic        ioWr_q, ioWr_d;
  logic [7:0]  ioAddr_q, ioAddr_d;
  logic [15:0] ioWrdata_q, ioWrdata_d;
  logic [15:0] ioRdata_q, ioRdata_d;
  logic        ioRespValid;

  assign memReq        = i_mem_rd | i_mem_wr;
  assign reqIo         = (i_mem_addr >= IO_BASE);
  assign accept        = memReq & ~memWait;
  assign ramAccept     = accept & ~reqIo;
  assign ramReadAccept = ramAccept & i_mem_rd;

  // Backpressure. An I/O access must wait for every outstanding RAM read
  // to return so that responses can never overlap or come back out of
  // order; a RAM read waits when the return pipeline is already full.
  always_comb begin
    memWait = 1'b0;
    if (memReq) begin
      if (state_q != IDLE) begin
        memWait = 1'b1;
      end else if (reqIo && (count_q != 3'd0)) begin
        memWait = 1'b1;
      end else if (!reqIo && i_mem_rd && (count_q == MAX_CNT)) begin
        memWait = 1'b1;
      end
    end
  end

  // The valid shift register follows each RAM read strobe down the RAM's
  // fixed latency; its tail lines up with the cycle the RAM data is valid.
  assign validShift = {valid_q, ramRd_q};
  assign ramTail    = valid_q[RAM_LATENCY-1];

  // Outstanding-read counter: reads are counted in at accept and counted
  // out on the cycle their response is presented to the CPU.
  always_comb begin
    count_d = count_q;
    if (ramReadAccept && !ramRespValid_q) begin
      count_d = count_q + 3'd1;
    end else if (!ramReadAccept && ramRespValid_q) begin
      count_d = count_q - 3'd1;
    end
  end

  // Response mux. RAM and I/O responses cannot coincide because of the
  // ordering enforced by the backpressure logic.
  always_comb begin
    rdValid_d = 1'b0;
    rdData_d  = rdData_q;
    if (ramTail) begin
      rdValid_d = 1'b1;
      rdData_d  = i_ram_rddata;
    end else if (ioRespValid) begin
      rdValid_d = 1'b1;
      rdData_d  = ioRdata_q;
    end
  end

  // RAM command issue, return pipeline and the CPU response register.
  // A read with the write strobe also high is issued as a plain read.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramRd_q        <= 1'b0;
      ramWr_q        <= 1'b0;
      ramAddr_q      <= 16'h0000;
      ramWrdata_q    <= 16'h0000;
      valid_q        <= '0;
      ramRespValid_q <= 1'b0;
      count_q        <= 3'd0;
      rdValid_q      <= 1'b0;
      rdData_q       <= 16'h0000;
    end else begin
      ramRd_q <= ramReadAccept;
      ramWr_q <= ramAccept & ~i_mem_rd;
      if (ramAccept) begin
        ramAddr_q   <= i_mem_addr;
        ramWrdata_q <= i_mem_wrdata;
      end
      valid_q        <= validShift[RAM_LATENCY-1:0];
      ramRespValid_q <= ramTail;
      count_q        <= count_d;
      rdValid_q      <= rdValid_d;
      rdData_q       <= rdData_d;
    end
  end

  // I/O FSM next state. The strobes are held from accept until ready is
  // seen; a completed read spends one cycle in IO_RESP to hand its captured
  // data to the response register.
  always_comb begin
    state_d     = state_q;
    ioRd_d      = ioRd_q;
    ioWr_d      = ioWr_q;
    ioAddr_d    = ioAddr_q;
    ioWrdata_d  = ioWrdata_q;
    ioRdata_d   = ioRdata_q;
    ioRespValid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && reqIo) begin
          state_d    = IO_ACCESS;
          ioAddr_d   = i_mem_addr[7:0];
          ioWrdata_d = i_mem_wrdata;
          ioRd_d     = i_mem_rd;
          ioWr_d     = ~i_mem_rd;
        end
      end
      IO_ACCESS: begin
        if (i_io_ready) begin
          ioRd_d = 1'b0;
          ioWr_d = 1'b0;
          if (ioRd_q) begin
            ioRdata_d = i_io_rddata;
            state_d   = IO_RESP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IO_RESP: begin
        ioRespValid = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // I/O FSM state and request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ioRd_q     <= 1'b0;
      ioWr_q     <= 1'b0;
      ioAddr_q   <= 8'h00;
      ioWrdata_q <= 16'h0000;
      ioRdata_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      ioRd_q     <= ioRd_d;
      ioWr_q     <= ioWr_d;
      ioAddr_q   <= ioAddr_d;
      ioWrdata_q <= ioWrdata_d;
      ioRdata_q  <= ioRdata_d;
    end
  end

  assign o_mem_wait        = memWait;
  assign o_mem_rddata      = rdData_q;
  assign o_mem_rddatavalid = rdValid_q;
  assign o_ram_addr        = ramAddr_q;
  assign o_ram_rd          = ramRd_q;
  assign o_ram_wr          = ramWr_q;
  assign o_ram_wrdata      = ramWrdata_q;
  assign o_io_addr         = ioAddr_q;
  assign o_io_rd           = ioRd_q;
  assign o_io_wr           = ioWr_q;
  assign o_io_wrdata       = ioWrdata_q;

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Sits directly downstream of the 16-bit CPU's memory port.
- Accepts the CPU's rd/wr/addr/wrdata requests and returns read data in order with a rddatavalid pulse.
- Applies wait backpressure to the CPU.
- Routes each access to either a fixed-latency synchronous RAM or a variable-latency memory-mapped I/O port with a ready handshake.

Parameters:
- RAM_LATENCY, 2: cycles from ram_rd high to valid ram_rddata; legal range 1..4.
- MAX_OUTSTANDING, 2: maximum accepted RAM reads not yet returned; legal range 1..4.
- IO_BASE, 16'hFF00: addresses >= IO_BASE go to the I/O port; all lower addresses go to RAM.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_mem_addr  in  16  CPU request address.
- i_mem_rd  in  1  CPU read request.
- i_mem_wr  in  1  CPU write request.
- i_mem_wrdata  in  16  CPU write data.
- o_mem_wait  out  1  backpressure; the CPU holds its request stable while high.
- o_mem_rddata  out  16  read data to the CPU.
- o_mem_rddatavalid  out  1  one-cycle pulse; o_mem_rddata is valid in that cycle.
- o_ram_addr  out  16  RAM address.
- o_ram_rd  out  1  RAM read strobe.
- o_ram_wr  out  1  RAM write strobe.
- o_ram_wrdata  out  16  RAM write data.
- i_ram_rddata  in  16  RAM read data, valid exactly RAM_LATENCY cycles after o_ram_rd.
- o_io_addr  out  8  I/O register offset, equal to addr[7:0].
- o_io_rd  out  1  I/O read request.
- o_io_wr  out  1  I/O write request.
- o_io_wrdata  out  16  I/O write data.
- i_io_rddata  in  16  I/O read data, sampled when i_io_ready is high.
- i_io_ready  in  1  I/O completion; held for one or more cycles after o_io_rd/o_io_wr.

Behaviour:
- Request and acceptance:
  - A request is present when i_mem_rd or i_mem_wr is high.
  - A request is accepted on any rising edge where a request is present and o_mem_wait is low.
  - If i_mem_rd and i_mem_wr are both high, the request is treated as a read and the write is dropped.
- o_mem_wait is combinational and is high when a request is present AND any of the following holds:
  - state != IDLE;
  - the request is a RAM read and count == MAX_OUTSTANDING;
  - the request is an I/O access and count != 0.
- o_mem_wait is low whenever no request is present.
- count (3 bits):
  - +1 on an accepted RAM read; -1 on a RAM-sourced rddatavalid.
  - Both events in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- RAM path:
  - An accepted RAM access is registered into o_ram_addr/o_ram_wrdata, with o_ram_rd or o_ram_wr pulsed high for exactly 1 cycle on the following cycle.
  - A valid-bit shift register of length RAM_LATENCY tracks each o_ram_rd.
  - When the tail bit is set, i_ram_rddata is captured into o_mem_rddata and o_mem_rddatavalid pulses on the next cycle.
  - Read latency from accept edge to rddatavalid = RAM_LATENCY + 2 cycles (4 at default).
  - Back-to-back reads accepted on consecutive cycles return on consecutive cycles, in order.
  - Writes do not affect count.
  - A write followed by a read to the same address returns the new data; RAM commands stay in order and the RAM is write-first.
- I/O FSM states: IDLE, IO_ACCESS, IO_RESP.
  - IDLE -> IO_ACCESS on an accepted I/O request. o_io_addr, o_io_wrdata and o_io_rd or o_io_wr are registered and held high.
  - IO_ACCESS: strobes stay high until i_io_ready is sampled high.
    - On ready for a read: capture i_io_rddata, go to IO_RESP.
    - On ready for a write: drop strobes, go to IDLE.
  - IO_RESP: o_mem_rddatavalid pulses with the captured data for 1 cycle, strobes are low, then go to IDLE.
  - Minimum I/O read latency, accept edge to rddatavalid, is 3 cycles, reached when i_io_ready is already high in the first IO_ACCESS cycle.
- Ordering: an I/O access is not accepted while any RAM read is outstanding. RAM and I/O responses therefore never overlap or reorder.
- Reset:
  - All outputs are driven to 0; o_mem_wait is 0 in the absence of a request.
  - count is set to 0, the valid pipeline is cleared, and state goes to IDLE.
  - RAM data arriving after reset for reads issued before it is discarded; no rddatavalid is produced for it.
  - A reset during IO_ACCESS drops the I/O strobes on the next cycle.

Test Plan:
1. Single RAM read: RAM holds 16'h1234 at address 16'h0010; read at cycle 0 -> o_ram_rd at cycle 1; o_mem_rddatavalid with 16'h1234 at cycle 4; wait stays 0.
2. Saturation: three reads held on consecutive cycles (addresses 0, 1, 2) -> reads 1 and 2 accepted; wait high on the third until the first rddatavalid; the three data words return in order.
3. Write-then-read: write 16'hBEEF to address 16'h0020, then read 16'h0020 on the next cycle -> exactly one o_ram_wr pulse; rddatavalid returns 16'hBEEF.
4. I/O read: address 16'hFF05 with i_io_ready asserted 3 cycles after o_io_rd and i_io_rddata = 16'h00A5 -> o_io_addr = 8'h05; wait high throughout; one rddatavalid with 16'h00A5; o_io_rd drops after ready.
5. I/O blocked by drain: RAM read at cycle 0, then I/O write to 16'hFF00 at cycle 1 -> wait high until the RAM rddatavalid at cycle 4; the I/O write is accepted afterwards.
6. Reset mid-read: two RAM reads accepted, reset pulsed 1 cycle later -> no rddatavalid ever appears; count is 0; a new read afterwards returns normally at RAM_LATENCY + 2.
